// File: rtl/tag_compare_unit_if.sv
// Bundle of tag-FIFO, R-channel and result signals around the tag compare stage.
// master: the compare unit; slave: the FIFO / memory controller / cache-control side.
interface tag_compare_unit_if #(
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 16,
  parameter int DATA_WIDTH   = 512,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int TID_WIDTH    = 10
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  logic                          tag_fifo_empty;
  logic                          tag_fifo_rden;
  logic [ADDR_WIDTH+TID_WIDTH:0] tag_fifo_data;

  logic [ID_WIDTH-1:0]           rid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  logic                          res_valid;
  logic                          res_ready;
  logic                          res_hit;
  logic                          res_dirty;
  logic                          res_err;
  logic                          res_wr;
  logic [TID_WIDTH-1:0]          res_tid;
  logic [ADDR_WIDTH-1:0]         res_addr;
  logic [TAG_WIDTH-1:0]          res_victim_tag;
  logic [31:0]                   hit_cnt;
  logic [31:0]                   miss_cnt;

  modport master (
    input  tag_fifo_empty, tag_fifo_data,
    input  rid, rdata, rresp, rlast, rvalid,
    input  res_ready,
    output tag_fifo_rden, rready,
    output res_valid, res_hit, res_dirty, res_err, res_wr, res_tid, res_addr,
    output res_victim_tag, hit_cnt, miss_cnt
  );

  modport slave (
    output tag_fifo_empty, tag_fifo_data,
    output rid, rdata, rresp, rlast, rvalid,
    output res_ready,
    input  tag_fifo_rden, rready,
    input  res_valid, res_hit, res_dirty, res_err, res_wr, res_tid, res_addr,
    input  res_victim_tag, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/tag_compare_unit.sv
// Tag-check stage: pops one request, compares it against the tag entry on the R channel, emits hit/miss.
// Optional hit/miss statistics counters are built when TAG_CMP_STATS_EN is defined.
module tag_compare_unit #(
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 16,
  parameter int DATA_WIDTH   = 512,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int TID_WIDTH    = 10
)(
  input logic clk,
  input logic rst,
  tag_compare_unit_if.master bus
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_R, S_DRAIN, S_RESULT} state_t;

  state_t                state;
  logic                  rready;
  logic                  res_valid;
  logic                  res_hit;
  logic                  res_dirty;
  logic                  res_err;
  logic                  res_wr;
  logic [TID_WIDTH-1:0]  res_tid;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [TAG_WIDTH-1:0]  res_victim_tag;

  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  beat;
  logic                  accept;
  logic                  beat_hit;
  logic                  unused_bits;

  assign req_tag  = res_addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH];
  assign beat     = bus.rvalid && rready;
  assign accept   = res_valid && bus.res_ready;
  assign beat_hit = bus.rdata[TAG_WIDTH+1] && (bus.rdata[TAG_WIDTH-1:0] == req_tag) &&
                    (bus.rresp == 2'b00);

  // Pop is decoded from state so the entry arrives in S_LOAD, keeping pop-to-result at 3 cycles.
  assign bus.tag_fifo_rden = (state == S_IDLE) && !bus.tag_fifo_empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rready         <= 1'b0;
      res_valid      <= 1'b0;
      res_hit        <= 1'b0;
      res_dirty      <= 1'b0;
      res_err        <= 1'b0;
      res_wr         <= 1'b0;
      res_tid        <= '0;
      res_addr       <= '0;
      res_victim_tag <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.tag_fifo_empty) state <= S_LOAD;
        end
        S_LOAD: begin
          {res_wr, res_tid, res_addr} <= bus.tag_fifo_data;
          rready <= 1'b1;
          state  <= S_WAIT_R;
        end
        S_WAIT_R: begin
          // Only the first beat carries the tag entry; the rest of a burst is drained.
          if (beat) begin
            res_hit        <= beat_hit;
            res_dirty      <= bus.rdata[TAG_WIDTH];
            res_victim_tag <= bus.rdata[TAG_WIDTH-1:0];
            res_err        <= (bus.rresp != 2'b00);
            if (bus.rlast) begin
              rready    <= 1'b0;
              res_valid <= 1'b1;
              state     <= S_RESULT;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (beat && bus.rlast) begin
            rready    <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (accept) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          rready    <= 1'b0;
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rready         = rready;
  assign bus.res_valid      = res_valid;
  assign bus.res_hit        = res_hit;
  assign bus.res_dirty      = res_dirty;
  assign bus.res_err        = res_err;
  assign bus.res_wr         = res_wr;
  assign bus.res_tid        = res_tid;
  assign bus.res_addr       = res_addr;
  assign bus.res_victim_tag = res_victim_tag;

`ifdef TAG_CMP_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (res_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign bus.hit_cnt  = hit_cnt;
  assign bus.miss_cnt = miss_cnt;
`else
  assign bus.hit_cnt  = 32'd0;
  assign bus.miss_cnt = 32'd0;
`endif

  // R ID and the payload above the tag entry carry nothing this stage needs.
  assign unused_bits = ^{bus.rid, bus.rdata[DATA_WIDTH-1:TAG_WIDTH+2]};
endmodule
